// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit byte-masked LSU port onto a 256K x 16 async SRAM.
// Ports: i_req/i_wren/i_addr/i_wdata/i_bmask in; o_rdata/o_ack/o_busy out;
//        registered SRAM pins o_sram_* and tristate io_sram_dq.
module sram_ctrl #(
  parameter int unsigned ACCESS_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_wren,
  input  logic [18:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_bmask,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_busy,
  output logic [17:0] o_sram_addr,
  inout  wire  [15:0] io_sram_dq,
  output logic        o_sram_ce_n,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n
);

  localparam logic [3:0] CYC_LAST = 4'(ACCESS_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    LO_REC,
    HI,
    HI_REC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]  cnt_q, cnt_d;
  logic        wren_q;
  logic [16:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic [31:0] rbuf_q, rbuf_d;

  logic        accept;
  logic        last;
  logic        wren_n;
  logic [16:0] addr_n;
  logic [31:0] wdata_n;
  logic [3:0]  mask_n;
  logic [15:0] lo_me, hi_me;

  logic        ce_d, we_d, oe_d;
  logic        lb_d, ub_d;
  logic [17:0] saddr_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_out_q, dq_out_d;
  logic [31:0] rdata_d;

  logic unused_addr;
  assign unused_addr = ^i_addr[1:0];

  assign io_sram_dq = dq_oe_q ? dq_out_q : 16'bz;

  assign o_ack  = (state_q == DONE);
  assign o_busy = (state_q != IDLE);

  assign accept = (state_q == IDLE) && i_req;
  assign last   = (cnt_q == CYC_LAST);

  // Pins are registered from the next state, so the captured
  // request must be visible on the accept edge itself.
  assign wren_n  = accept ? i_wren        : wren_q;
  assign addr_n  = accept ? i_addr[18:2]  : addr_q;
  assign wdata_n = accept ? i_wdata       : wdata_q;
  assign mask_n  = accept ? i_bmask       : mask_q;

  assign lo_me = {{8{mask_q[1]}}, {8{mask_q[0]}}};
  assign hi_me = {{8{mask_q[3]}}, {8{mask_q[2]}}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rbuf_d  = rbuf_q;
    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          rbuf_d = '0;
          if (|i_bmask[1:0])      state_d = LO;
          else if (|i_bmask[3:2]) state_d = HI;
          else                    state_d = DONE;
        end
      end
      LO: begin
        if (last) begin
          cnt_d = '0;
          if (wren_q) begin
            state_d = LO_REC;
          end else begin
            rbuf_d[15:0] = io_sram_dq & lo_me;
            state_d = (|mask_q[3:2]) ? HI : DONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      LO_REC: begin
        state_d = (|mask_q[3:2]) ? HI : DONE;
      end
      HI: begin
        if (last) begin
          cnt_d = '0;
          if (wren_q) begin
            state_d = HI_REC;
          end else begin
            rbuf_d[31:16] = io_sram_dq & hi_me;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI_REC: state_d = DONE;
      DONE:   state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ce_d     = 1'b1;
    we_d     = 1'b1;
    oe_d     = 1'b1;
    lb_d     = 1'b1;
    ub_d     = 1'b1;
    dq_oe_d  = 1'b0;
    dq_out_d = dq_out_q;
    saddr_d  = o_sram_addr;
    unique case (state_d)
      LO, LO_REC: begin
        ce_d     = 1'b0;
        saddr_d  = {addr_n, 1'b0};
        lb_d     = ~mask_n[0];
        ub_d     = ~mask_n[1];
        dq_oe_d  = wren_n;
        dq_out_d = wdata_n[15:0];
        if (state_d == LO) begin
          we_d = ~wren_n;
          oe_d = wren_n;
        end
      end
      HI, HI_REC: begin
        ce_d     = 1'b0;
        saddr_d  = {addr_n, 1'b1};
        lb_d     = ~mask_n[2];
        ub_d     = ~mask_n[3];
        dq_oe_d  = wren_n;
        dq_out_d = wdata_n[31:16];
        if (state_d == HI) begin
          we_d = ~wren_n;
          oe_d = wren_n;
        end
      end
      default: ;
    endcase
  end

  // Read data is published only as the ack begins; writes leave it.
  assign rdata_d = ((state_d == DONE) && !wren_n) ? rbuf_d : o_rdata;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      rbuf_q      <= '0;
      o_rdata     <= '0;
      o_sram_addr <= '0;
      o_sram_ce_n <= 1'b1;
      o_sram_we_n <= 1'b1;
      o_sram_oe_n <= 1'b1;
      o_sram_lb_n <= 1'b1;
      o_sram_ub_n <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wren_q      <= wren_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      mask_q      <= mask_n;
      rbuf_q      <= rbuf_d;
      o_rdata     <= rdata_d;
      o_sram_addr <= saddr_d;
      o_sram_ce_n <= ce_d;
      o_sram_we_n <= we_d;
      o_sram_oe_n <= oe_d;
      o_sram_lb_n <= lb_d;
      o_sram_ub_n <= ub_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: drives sram_ctrl against an async SRAM model and
// checks results against a word-level memory reference.
module tb_sram_ctrl;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        wren = 1'b0;
  logic [18:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  bmask = '0;
  logic        probe = 1'b0;

  wire  [31:0] rdata;
  wire         ack, busy;
  wire  [17:0] saddr;
  wire  [15:0] dq;
  wire         ce_n, we_n, oe_n, lb_n, ub_n;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [0:63];
  logic [31:0] last_rd = '0;

  logic [17:0] lo_addr, hi_addr;
  logic [15:0] lo_dq, hi_dq;
  logic [1:0]  lo_bu, hi_bu;
  int          lo_ce;

  logic [15:0] sram [0:127];

  sram_ctrl #(.ACCESS_CYC(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (req),
    .i_wren      (wren),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_bmask     (bmask),
    .o_rdata     (rdata),
    .o_ack       (ack),
    .o_busy      (busy),
    .o_sram_addr (saddr),
    .io_sram_dq  (dq),
    .o_sram_ce_n (ce_n),
    .o_sram_we_n (we_n),
    .o_sram_oe_n (oe_n),
    .o_sram_lb_n (lb_n),
    .o_sram_ub_n (ub_n)
  );

  always #5 clk = ~clk;

  wire sram_drv = !ce_n && !oe_n && we_n;
  assign dq = sram_drv ? sram[saddr[6:0]] :
              probe    ? 16'hA5C3 : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) sram[saddr[6:0]][7:0]  <= dq[7:0];
      if (!ub_n) sram[saddr[6:0]][15:8] <= dq[15:8];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mexp(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  task automatic txn(input logic        w,
                     input logic [5:0]  word,
                     input logic [31:0] wd,
                     input logic [3:0]  m);
    int lat, we_lo, oe_lo, ce_lo, bsy, conf, bad_a;
    int halves, exp_lat;
    logic [31:0] me;
    lat = 0; we_lo = 0; oe_lo = 0; ce_lo = 0;
    bsy = 0; conf = 0; bad_a = 0; lo_ce = 0;
    lo_addr = '1; hi_addr = '1;
    lo_dq = '0; hi_dq = '0; lo_bu = '1; hi_bu = '1;
    addr  = {11'd0, word, 2'($urandom)};
    wren  = w;
    wdata = wd;
    bmask = m;
    req   = 1'b1;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        addr  = 19'($urandom);
        wdata = $urandom;
        bmask = 4'($urandom);
        wren  = 1'($urandom);
      end
      if (busy) bsy++;
      if (!we_n) we_lo++;
      if (!oe_n) oe_lo++;
      if (!ce_n) ce_lo++;
      if (!we_n && !oe_n) conf++;
      if (!ce_n && saddr[17:1] != {11'd0, word}) bad_a++;
      if (!ce_n && !saddr[0]) lo_ce++;
      if (!we_n && !saddr[0]) begin
        lo_addr = saddr; lo_dq = dq; lo_bu = {lb_n, ub_n};
      end
      if (!we_n && saddr[0]) begin
        hi_addr = saddr; hi_dq = dq; hi_bu = {lb_n, ub_n};
      end
    end while (!ack && lat < 100);
    req = 1'b0;
    halves  = int'(|m[1:0]) + int'(|m[3:2]);
    exp_lat = (halves == 0) ? 1 :
              w ? halves * (N + 1) + 1 : halves * N + 1;
    me = mexp(m);
    if (w) ref_mem[word] = (ref_mem[word] & ~me) | (wd & me);
    else   last_rd = ref_mem[word] & me;
    chk("latency", lat, exp_lat);
    chk("busy_cycles", bsy, exp_lat);
    chk("we_low", we_lo, w ? halves * N : 0);
    chk("oe_low", oe_lo, w ? 0 : halves * N);
    chk("ce_low", ce_lo, halves * (N + int'(w)));
    chk("bus_conflict", conf, 0);
    chk("addr_word", bad_a, 0);
    chk("rdata", rdata, last_rd);
    @(negedge clk);
    chk("ack_pulse", {31'd0, ack}, 32'd0);
  endtask

  task automatic idle_pins(input string tag);
    probe = 1'b1;
    #1;
    chk({tag, "_strobes"}, {27'd0, ce_n, we_n, oe_n, lb_n, ub_n},
        32'h1f);
    chk({tag, "_dq"}, {16'd0, dq}, 32'h0000A5C3);
    chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_saddr"}, {14'd0, saddr}, 32'd0);
    probe = 1'b0;
  endtask

  initial begin
    int cnt;
    // Reset held for two cycles.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_pins("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Populate every word through the controller.
    for (int i = 0; i < 64; i++) txn(1'b1, 6'(i), $urandom, 4'hf);

    // Full write at byte address 0x10.
    txn(1'b1, 6'd4, 32'hDEADBEEF, 4'hf);
    chk("fw_lo_addr", {14'd0, lo_addr}, 32'h8);
    chk("fw_lo_dq", {16'd0, lo_dq}, 32'hBEEF);
    chk("fw_hi_addr", {14'd0, hi_addr}, 32'h9);
    chk("fw_hi_dq", {16'd0, hi_dq}, 32'hDEAD);

    // Full read back.
    txn(1'b0, 6'd4, 32'd0, 4'hf);
    chk("fr_value", rdata, 32'hDEADBEEF);

    // Single byte write into byte 2.
    txn(1'b1, 6'd4, 32'h00AB0000, 4'h4);
    chk("bw_lo_ce", lo_ce, 0);
    chk("bw_hi_dq", {16'd0, hi_dq}, 32'h00AB);
    chk("bw_hi_lbub", {30'd0, hi_bu}, 32'h1);
    txn(1'b0, 6'd4, 32'd0, 4'hf);
    chk("bw_readback", rdata, 32'hDEABBEEF);

    // Mask 0 and low-half read.
    txn(1'b0, 6'd4, 32'd0, 4'h0);
    txn(1'b1, 6'd9, 32'h12345678, 4'h0);
    txn(1'b0, 6'd4, 32'd0, 4'h3);
    chk("m3_upper", {16'd0, rdata[31:16]}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++)
      txn(1'($urandom), 6'($urandom), $urandom, 4'($urandom));

    // Reset during the high-half write.
    addr  = {11'd0, 6'd5, 2'b00};
    wren  = 1'b1;
    wdata = 32'hCAFEF00D;
    bmask = 4'hf;
    req   = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(!we_n && saddr[0]) && cnt < 30);
    chk("mid_reached_hi", {31'd0, (!we_n && saddr[0])}, 32'd1);
    rst_n = 1'b0;
    req   = 1'b0;
    @(negedge clk);
    idle_pins("midrst");
    @(negedge clk);
    chk("midrst_noack", {31'd0, ack}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_noack2", {31'd0, ack}, 32'd0);
    last_rd = '0;
    txn(1'b1, 6'd5, 32'h0BADC0DE, 4'hf);
    txn(1'b0, 6'd5, 32'd0, 4'hf);
    chk("post_reset_read", rdata, 32'h0BADC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
